// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply operand loader.
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        START   = 2'd2,
        RELEASE = 2'd3
    } loader_state_t;

    localparam int MM_N        = 4;
    localparam int TOT_ELEMS   = MM_N * MM_N;
    localparam int FRAME_ELEMS = 2 * MM_N * MM_N;
    localparam int ELEM_IDX_W  = $clog2(TOT_ELEMS);

    function automatic int tot_elems(input int n);
        return n * n;
    endfunction

    function automatic int frame_elems(input int n);
        return 2 * n * n;
    endfunction

    // Width of the flat per-matrix element index; never below 1 bit.
    function automatic int elem_idx_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/matmul_operand_loader.sv
// Loads a row-major A-then-B element stream into stable register arrays and
// drives the engine's level start/done handshake, one loader per engine.
module matmul_operand_loader
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int JOB_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_last,
    output logic [N-1:0][N-1:0][DATA_W-1:0]   A_out,
    output logic [N-1:0][N-1:0][DATA_W-1:0]   B_out,
    output logic                              mm_start,
    input  logic                              mm_done,
    output logic                              busy,
    output logic                              frame_err,
    output logic [JOB_W-1:0]                  job_count,
    output loader_state_t                     dbg_state
);

    localparam int IDX_W = elem_idx_w(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(tot_elems(N) - 1);

    // Handshake: an element transfers on a rising clk edge where in_valid and
    // in_ready are both high; the upstream must hold in_data/in_last stable
    // while in_valid is high and in_ready is low.

    loader_state_t                     state_q;
    logic [IDX_W-1:0]                  cnt_q;
    logic [N-1:0][N-1:0][DATA_W-1:0]   a_q;
    logic [N-1:0][N-1:0][DATA_W-1:0]   b_q;
    logic                              mm_start_q;
    logic                              frame_err_q;
    logic [JOB_W-1:0]                  job_q;

    logic accept;
    logic last_of_matrix;
    logic final_elem;

    assign in_ready       = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign accept         = in_valid && in_ready;
    assign last_of_matrix = (cnt_q == LAST_IDX);
    assign final_elem     = (state_q == LOAD_B) && last_of_matrix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mm_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            job_q       <= '0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                LOAD_A, LOAD_B: begin
                    if (accept) begin
                        if (in_last && !final_elem) begin
                            // Early in_last: drop the element and resync to a new frame.
                            frame_err_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= LOAD_A;
                        end else begin
                            for (int r = 0; r < N; r++) begin
                                for (int c = 0; c < N; c++) begin
                                    if (cnt_q == IDX_W'(r * N + c)) begin
                                        if (state_q == LOAD_A) a_q[r][c] <= in_data;
                                        else                   b_q[r][c] <= in_data;
                                    end
                                end
                            end
                            if (last_of_matrix) begin
                                cnt_q <= '0;
                                if (state_q == LOAD_A) begin
                                    state_q <= LOAD_B;
                                end else begin
                                    // Missing in_last on the final element is flagged but still launches.
                                    state_q     <= START;
                                    mm_start_q  <= 1'b1;
                                    frame_err_q <= !in_last;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                end
                START: begin
                    if (mm_done) begin
                        mm_start_q <= 1'b0;
                        job_q      <= job_q + 1'b1;
                        state_q    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!mm_done) state_q <= LOAD_A;
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    assign A_out     = a_q;
    assign B_out     = b_q;
    assign mm_start  = mm_start_q;
    assign frame_err = frame_err_q;
    assign job_count = job_q;
    assign busy      = (state_q != LOAD_A) || (cnt_q != '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Self-checking bench for matmul_operand_loader: table of frame scenarios,
// hand-written handshake/reset sequences and randomized frames against a model.
module tb_matmul_operand_loader;
    import matmul_pkg::*;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int JOB_W  = 4;
    localparam int NN     = N * N;
    localparam int FR     = 2 * N * N;

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic                            in_valid = 1'b0;
    logic                            in_last = 1'b0;
    logic [DATA_W-1:0]               in_data = '0;
    logic                            mm_done = 1'b0;
    logic                            in_ready;
    logic                            mm_start;
    logic                            busy;
    logic                            frame_err;
    logic [JOB_W-1:0]                job_count;
    logic [N-1:0][N-1:0][DATA_W-1:0] A_out;
    logic [N-1:0][N-1:0][DATA_W-1:0] B_out;
    loader_state_t                   dbg_state;

    matmul_operand_loader #(.N(N), .DATA_W(DATA_W), .JOB_W(JOB_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .A_out(A_out), .B_out(B_out),
        .mm_start(mm_start), .mm_done(mm_done), .busy(busy),
        .frame_err(frame_err), .job_count(job_count), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    int fe_cnt = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (frame_err) fe_cnt++;

    // scoreboard state
    int vec_cnt = 0;
    int err_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_a[N][N];
    logic [DATA_W-1:0] m_b[N][N];
    logic [JOB_W-1:0]  exp_job = '0;

    typedef struct {
        int pat;        // 0: A=identity, B=ramp; 1: random data
        int last_pos;   // index carrying in_last, -1 for none
        int gap;        // percent chance of an idle cycle before each element
        int start_lat;
        int done_len;
        bit exp_err;
        bit exp_launch;
    } frame_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                m_a[r][c] = '0;
                m_b[r][c] = '0;
            end
        exp_q.delete();
        exp_job = '0;
    endtask

    // driver: one element, optional idle gap, bounded wait for acceptance
    task automatic send_elem(input logic [DATA_W-1:0] d, input bit last, input int gap, output bit ok);
        bit acc;
        int budget;
        ok = 1'b0;
        budget = 200;
        while (int'($urandom_range(99)) < gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (budget > 0) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
            budget--;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int pat, input int last_pos, input int gap,
                              output bit err_o, output bit launch_o);
        bit ok;
        bit lst;
        logic [DATA_W-1:0] d;
        err_o = 1'b0;
        launch_o = 1'b0;
        for (int p = 0; p < FR; p++) begin
            if (pat == 0)
                d = (p < NN) ? (((p / N) == (p % N)) ? 32'd1 : 32'd0) : DATA_W'(p - NN);
            else
                d = $urandom();
            lst = (p == last_pos);
            if (p == FR - 1) check("mm_start_before_final", {63'd0, mm_start}, 64'd0);
            send_elem(d, lst, gap, ok);
            if (!ok) begin
                check("accept_timeout", 64'd0, 64'd1);
                return;
            end
            if (lst && p != FR - 1) begin
                err_o = 1'b1;
                check("frame_err_abort", {63'd0, frame_err}, 64'd1);
                check("busy_after_abort", {63'd0, busy}, 64'd0);
                return;
            end
            if (p < NN) m_a[p / N][p % N] = d;
            else        m_b[(p - NN) / N][(p - NN) % N] = d;
            if (p == FR - 1) begin
                launch_o = 1'b1;
                err_o = !lst;
                check("frame_err_final", {63'd0, frame_err}, {63'd0, !lst});
                check("mm_start_rise", {63'd0, mm_start}, 64'd1);
                for (int q = 0; q < FR; q++)
                    exp_q.push_back((q < NN) ? m_a[q / N][q % N] : m_b[(q - NN) / N][(q - NN) % N]);
            end
        end
    endtask

    task automatic check_launch();
        logic [DATA_W-1:0] e;
        for (int p = 0; p < FR; p++) begin
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 64'd0, 64'd1);
                return;
            end
            e = exp_q.pop_front();
            if (p < NN) check($sformatf("A_out[%0d]", p), {32'd0, A_out[p / N][p % N]}, {32'd0, e});
            else        check($sformatf("B_out[%0d]", p - NN), {32'd0, B_out[(p - NN) / N][(p - NN) % N]}, {32'd0, e});
        end
    endtask

    // engine stub: hold off start_lat cycles, raise done for done_len cycles,
    // while upstream keeps offering a junk element that must not be taken
    task automatic run_job(input int start_lat, input int done_len);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b0;
        for (int i = 0; i < start_lat; i++) begin
            check("in_ready_start", {63'd0, in_ready}, 64'd0);
            check("mm_start_hold", {63'd0, mm_start}, 64'd1);
            @(posedge clk); #1;
        end
        check_launch();
        mm_done = 1'b1;
        @(posedge clk); #1;
        exp_job = exp_job + 1'b1;
        check("mm_start_fall", {63'd0, mm_start}, 64'd0);
        check("job_count", {60'd0, job_count}, {60'd0, exp_job});
        for (int i = 1; i < done_len; i++) begin
            check("in_ready_release", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        mm_done = 1'b0;
        check("in_ready_before_done_fall", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        check("in_ready_return", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        check("busy_idle", {63'd0, busy}, 64'd0);
        check("A_out_untouched", {32'd0, A_out[0][0]}, {32'd0, m_a[0][0]});
    endtask

    frame_vec_t tbl[8];

    initial begin
        bit err, launch;
        int fe0, c0, lp;

        tbl[0] = '{0, FR - 1, 0,  5, 3, 1'b0, 1'b1};
        tbl[1] = '{0, FR - 1, 50, 5, 3, 1'b0, 1'b1};
        tbl[2] = '{1, 9,      0,  5, 3, 1'b1, 1'b0};
        tbl[3] = '{1, FR - 1, 0,  2, 1, 1'b0, 1'b1};
        tbl[4] = '{1, -1,     30, 4, 2, 1'b1, 1'b1};
        tbl[5] = '{1, 20,     0,  1, 1, 1'b1, 1'b0};
        tbl[6] = '{1, 0,      0,  1, 1, 1'b1, 1'b0};
        tbl[7] = '{1, FR - 1, 40, 1, 5, 1'b0, 1'b1};

        model_reset();
        #12;
        check("rst_A_out", {63'd0, A_out != '0}, 64'd0);
        check("rst_B_out", {63'd0, B_out != '0}, 64'd0);
        check("rst_mm_start", {63'd0, mm_start}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("rst_job_count", {60'd0, job_count}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // table-driven frame scenarios
        for (int v = 0; v < 8; v++) begin
            fe0 = fe_cnt;
            c0  = cyc;
            send_frame(tbl[v].pat, tbl[v].last_pos, tbl[v].gap, err, launch);
            if (tbl[v].gap == 0 && tbl[v].exp_launch)
                check($sformatf("v%0d_frame_cycles", v), 64'(cyc - c0), 64'(FR));
            check($sformatf("v%0d_launch", v), {63'd0, mm_start}, {63'd0, tbl[v].exp_launch});
            if (launch) run_job(tbl[v].start_lat, tbl[v].done_len);
            @(posedge clk); #1;
            check($sformatf("v%0d_frame_err_pulses", v), 64'(fe_cnt - fe0), {63'd0, tbl[v].exp_err});
        end

        // reset while the engine is being started
        send_frame(1, FR - 1, 0, err, launch);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_mm_start", {63'd0, mm_start}, 64'd0);
        check("midrst_job_count", {60'd0, job_count}, 64'd0);
        check("midrst_A_out", {63'd0, A_out != '0}, 64'd0);
        check("midrst_B_out", {63'd0, B_out != '0}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);

        // randomized frames against the model; enough jobs to wrap job_count
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(9) == 0)      lp = int'($urandom_range(FR - 2));
            else if ($urandom_range(9) == 0) lp = -1;
            else                             lp = FR - 1;
            fe0 = fe_cnt;
            send_frame(1, lp, int'($urandom_range(60)), err, launch);
            if (launch) run_job(int'($urandom_range(6, 1)), int'($urandom_range(4, 1)));
            @(posedge clk); #1;
            check($sformatf("r%0d_frame_err_pulses", k), 64'(fe_cnt - fe0), {63'd0, err});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
